clock_timekeeper: RTL
=====================

# clock_timekeeper

Time-of-day and weekday counter feeding the character LCD driver. Divides the 54 MHz system clock into seconds, rolls seconds/minutes/hours/weekday, and exposes the raw sub-second count used by the display for colon blinking. Two debounced push-buttons provide a set mode for hour, minute and weekday.

## Interface
- CLK_HZ, 54_000_000: clock cycles per second; cnt wraps at CLK_HZ-1.
- DB_CYCLES, 540_000: debounce window in cycles (10 ms at 54 MHz).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- btn_up  in  1  raw increment button, active-high, asynchronous to clk.
- cnt  out  28  sub-second count, 0..CLK_HZ-1.
- sec  out  6  seconds, 0..59.
- min  out  6  minutes, 0..59.
- hour  out  5  hours, 0..23.
- day_cnt  out  3  weekday, 0=MON..6=SUN.
- mode_sel  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_DAY.

## Operation
- Button path, per button: 2-FF synchronizer -> debouncer -> rising-edge detector.
- Debouncer: stable level updates only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any agreement restarts the count.
- Press pulse: exactly one cycle, on the cycle after the stable level goes 0->1. Releases produce no pulse.
- FSM on mode press: RUN -> SET_HOUR -> SET_MIN -> SET_DAY -> RUN. mode_sel encodes current state.
- cnt always free-runs in every state: cnt==CLK_HZ-1 -> 0 (tick), else +1.
- RUN: on tick, sec+1; sec 59->0 carries min+1; min 59->0 carries hour+1; hour 23->0 carries day_cnt+1; day_cnt 6->0. Full carry chain resolves in the single tick cycle (23:59:59 SUN -> 00:00:00 MON in one edge).
- RUN: up presses ignored.
- SET_*: ticks do not advance sec or any field. Up press increments only the selected field with wrap (hour 23->0, min 59->0, day 6->0), no carry to other fields.
- Leaving SET_DAY -> RUN: sec and cnt cleared to 0 on that same edge, so the first second after setting is a full second.
- Mode and up pulses in the same cycle: up applies to the current (pre-transition) field, mode advances state.
- Field values outside legal range cannot occur; no recovery logic required beyond reset.

## Timing
- Reset (async assert, sync-free deassert): cnt=0, sec=0, min=0, hour=0, day_cnt=0, mode_sel=0, synchronizers, debounce counters, stable levels and edge registers all 0.
- Reset mid-set: returns to RUN with 00:00:00 MON; pending debounce state discarded.
- All outputs registered; field updates visible the cycle after tick or press pulse.
- Button latency: raw edge to press pulse = 2 sync cycles + DB_CYCLES + 1, ±1 cycle for sampling phase.
- Glitches shorter than DB_CYCLES cycles produce no pulse.
- sec increments once per CLK_HZ cycles exactly in RUN; no drift, no skipped ticks.

## Test plan
- CLK_HZ=10, DB_CYCLES=4: release reset, run 600 cycles -> sec returns to 0, min=1, cnt cycles 0..9 each second.
- Preload via set mode to hour=23 min=59 day_cnt=6, return to RUN, run 60 s -> single edge shows hour=0, min=0, sec=0, day_cnt=0.
- btn_mode held 3 cycles then released -> no pulse, mode_sel stays 0; held 10 cycles -> mode_sel=1 exactly once.
- In SET_MIN with min=59, one up press -> min=0, hour unchanged; ticks during set leave sec unchanged.
- Mode press from SET_DAY with cnt=7, sec=42 -> mode_sel=0, sec=0, cnt=0 next cycle.
- Assert reset while mode_sel=2 and btn_up bouncing -> all outputs 0 immediately, no pulse after deassert until a fresh stable press.

Source files
------------

// File: rtl/clock_timekeeper.sv
// Time-of-day / weekday counter with a free-running sub-second count and a
// two-button (mode/up) set interface; every output comes straight from a register.
module clock_timekeeper #(
  parameter int CLK_HZ    = 54_000_000,
  parameter int DB_CYCLES = 540_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_up,
  output logic [27:0] cnt,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic [2:0]  day_cnt,
  output logic [1:0]  mode_sel
);

  localparam int DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_DAY  = 2'd3
  } state_t;

  // Button path; bit 0 is mode, bit 1 is up.
  logic [1:0]          w_raw;
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_stable;
  logic [1:0]          r_stable_d;
  logic [1:0][DBW-1:0] r_db_cnt;
  logic [1:0]          w_press;
  logic                w_mode_pls;
  logic                w_up_pls;

  state_t r_state;
  state_t w_state_nxt;

  logic w_run;
  logic w_inc_hour;
  logic w_inc_min;
  logic w_inc_day;
  logic w_resume;

  logic [27:0] r_cnt;
  logic [5:0]  r_sec;
  logic [5:0]  r_min;
  logic [4:0]  r_hour;
  logic [2:0]  r_day;

  logic w_tick;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;
  logic w_day_wrap;
  logic w_adv_sec;
  logic w_adv_min;
  logic w_adv_hour;
  logic w_adv_day;

  assign w_raw = {btn_up, btn_mode};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable_d <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
    end
  end

  // Stable level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press    = r_stable & ~r_stable_d;
  assign w_mode_pls = w_press[0];
  assign w_up_pls   = w_press[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_pls) begin
      case (r_state)
        ST_RUN:  w_state_nxt = ST_HOUR;
        ST_HOUR: w_state_nxt = ST_MIN;
        ST_MIN:  w_state_nxt = ST_DAY;
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Up pulse acts on the field of the current state even if mode leaves it this cycle.
  always_comb begin
    w_run      = 1'b0;
    w_inc_hour = 1'b0;
    w_inc_min  = 1'b0;
    w_inc_day  = 1'b0;
    w_resume   = 1'b0;
    case (r_state)
      ST_RUN:  w_run      = 1'b1;
      ST_HOUR: w_inc_hour = w_up_pls;
      ST_MIN:  w_inc_min  = w_up_pls;
      default: begin
        w_inc_day = w_up_pls;
        w_resume  = w_mode_pls;
      end
    endcase
  end

  assign w_tick      = (r_cnt == 28'(CLK_HZ - 1));
  assign w_sec_wrap  = (r_sec == 6'd59);
  assign w_min_wrap  = (r_min == 6'd59);
  assign w_hour_wrap = (r_hour == 5'd23);
  assign w_day_wrap  = (r_day == 3'd6);

  // Whole carry chain settles in the tick cycle.
  assign w_adv_sec  = w_run & w_tick;
  assign w_adv_min  = w_adv_sec & w_sec_wrap;
  assign w_adv_hour = w_adv_min & w_min_wrap;
  assign w_adv_day  = w_adv_hour & w_hour_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_resume || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 28'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec <= '0;
    end else if (w_resume) begin
      r_sec <= '0;
    end else if (w_adv_sec) begin
      r_sec <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_min  <= '0;
      r_hour <= '0;
      r_day  <= '0;
    end else begin
      if (w_adv_min || w_inc_min) begin
        r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
      end
      if (w_adv_hour || w_inc_hour) begin
        r_hour <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
      end
      if (w_adv_day || w_inc_day) begin
        r_day <= w_day_wrap ? 3'd0 : r_day + 3'd1;
      end
    end
  end

  assign cnt      = r_cnt;
  assign sec      = r_sec;
  assign min      = r_min;
  assign hour     = r_hour;
  assign day_cnt  = r_day;
  assign mode_sel = r_state;

endmodule
